// File: rtl/addr_xlate_unit.sv
// Registered virtual-to-physical address translation with a programmable region table,
// per-region store permission, access faults and a lossless valid/ready output with skid.
module addr_xlate_unit #(
  parameter int ADDR_W      = 64,
  parameter int NUM_REGIONS = 4,
  parameter int PASSTHRU    = 1,
  localparam int RI_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [RI_W-1:0]   cfg_idx,
  input  logic              cfg_en,
  input  logic              cfg_wr_ok,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic [ADDR_W-1:0] cfg_offset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_vaddr,
  input  logic              req_we,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_paddr,
  output logic              resp_fault,
  output logic [RI_W-1:0]   resp_region,
  output logic [15:0]       fault_cnt
);

  logic              en_q     [NUM_REGIONS];
  logic              en_d     [NUM_REGIONS];
  logic              wr_ok_q  [NUM_REGIONS];
  logic              wr_ok_d  [NUM_REGIONS];
  logic [ADDR_W-1:0] base_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] base_d   [NUM_REGIONS];
  logic [ADDR_W-1:0] mask_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] mask_d   [NUM_REGIONS];
  logic [ADDR_W-1:0] offset_q [NUM_REGIONS];
  logic [ADDR_W-1:0] offset_d [NUM_REGIONS];

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_paddr_q, out_paddr_d;
  logic              out_fault_q, out_fault_d;
  logic [RI_W-1:0]   out_region_q, out_region_d;
  logic              skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] skid_paddr_q, skid_paddr_d;
  logic              skid_fault_q, skid_fault_d;
  logic [RI_W-1:0]   skid_region_q, skid_region_d;
  logic [15:0]       fault_cnt_q, fault_cnt_d;

  logic              hit_any_s;
  logic [RI_W-1:0]   hit_idx_s;
  logic [ADDR_W-1:0] new_paddr_s;
  logic              new_fault_s;
  logic [RI_W-1:0]   new_region_s;
  logic              accept_s;
  logic              out_fire_s;

  // Table write: entries whose index never equals cfg_idx stay untouched, so
  // out-of-range indices are ignored without an explicit bound check.
  always_comb begin
    for (int i = 0; i < NUM_REGIONS; i++) begin
      en_d[i]     = en_q[i];
      wr_ok_d[i]  = wr_ok_q[i];
      base_d[i]   = base_q[i];
      mask_d[i]   = mask_q[i];
      offset_d[i] = offset_q[i];
      if (cfg_we && (cfg_idx == RI_W'(i))) begin
        en_d[i]     = cfg_en;
        wr_ok_d[i]  = cfg_wr_ok;
        base_d[i]   = cfg_base;
        mask_d[i]   = cfg_mask;
        offset_d[i] = cfg_offset;
      end else begin
        en_d[i]     = en_q[i];
      end
    end
  end

  // Priority match: scanning downward leaves the lowest hitting index selected.
  always_comb begin
    hit_any_s = 1'b0;
    hit_idx_s = {RI_W{1'b0}};
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (en_q[i] && ((req_vaddr & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
        hit_any_s = 1'b1;
        hit_idx_s = RI_W'(i);
      end else begin
        hit_any_s = hit_any_s;
      end
    end
  end

  // Translate at acceptance time so queued results are immune to later config writes.
  always_comb begin
    new_paddr_s  = req_vaddr;
    new_fault_s  = (PASSTHRU == 0);
    new_region_s = {RI_W{1'b0}};
    if (hit_any_s) begin
      new_paddr_s  = (offset_q[hit_idx_s] & mask_q[hit_idx_s]) |
                     (req_vaddr & ~mask_q[hit_idx_s]);
      new_fault_s  = req_we & ~wr_ok_q[hit_idx_s];
      new_region_s = hit_idx_s;
    end else begin
      new_paddr_s  = req_vaddr;
    end
  end

  assign accept_s   = req_valid & ~skid_valid_q;
  assign out_fire_s = out_valid_q & resp_ready;

  // Output register plus skid; the skid only fills while the output is stalled.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_paddr_d   = out_paddr_q;
    out_fault_d   = out_fault_q;
    out_region_d  = out_region_q;
    skid_valid_d  = skid_valid_q;
    skid_paddr_d  = skid_paddr_q;
    skid_fault_d  = skid_fault_q;
    skid_region_d = skid_region_q;
    if (out_fire_s || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_paddr_d  = skid_paddr_q;
        out_fault_d  = skid_fault_q;
        out_region_d = skid_region_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_valid_d  = 1'b1;
        out_paddr_d  = new_paddr_s;
        out_fault_d  = new_fault_s;
        out_region_d = new_region_s;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_d  = 1'b1;
      skid_paddr_d  = new_paddr_s;
      skid_fault_d  = new_fault_s;
      skid_region_d = new_region_s;
    end else begin
      skid_valid_d  = skid_valid_q;
    end
  end

  // Saturating count of faulted responses taken by the consumer.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (out_fire_s && out_fault_q && (fault_cnt_q != 16'hFFFF)) begin
      fault_cnt_d = fault_cnt_q + 16'd1;
    end else begin
      fault_cnt_d = fault_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        en_q[i]     <= 1'b0;
        wr_ok_q[i]  <= 1'b0;
        base_q[i]   <= {ADDR_W{1'b0}};
        mask_q[i]   <= {ADDR_W{1'b0}};
        offset_q[i] <= {ADDR_W{1'b0}};
      end
      out_valid_q   <= 1'b0;
      out_paddr_q   <= {ADDR_W{1'b0}};
      out_fault_q   <= 1'b0;
      out_region_q  <= {RI_W{1'b0}};
      skid_valid_q  <= 1'b0;
      skid_paddr_q  <= {ADDR_W{1'b0}};
      skid_fault_q  <= 1'b0;
      skid_region_q <= {RI_W{1'b0}};
      fault_cnt_q   <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        en_q[i]     <= en_d[i];
        wr_ok_q[i]  <= wr_ok_d[i];
        base_q[i]   <= base_d[i];
        mask_q[i]   <= mask_d[i];
        offset_q[i] <= offset_d[i];
      end
      out_valid_q   <= out_valid_d;
      out_paddr_q   <= out_paddr_d;
      out_fault_q   <= out_fault_d;
      out_region_q  <= out_region_d;
      skid_valid_q  <= skid_valid_d;
      skid_paddr_q  <= skid_paddr_d;
      skid_fault_q  <= skid_fault_d;
      skid_region_q <= skid_region_d;
      fault_cnt_q   <= fault_cnt_d;
    end
  end

  assign req_ready   = ~skid_valid_q;
  assign resp_valid  = out_valid_q;
  assign resp_paddr  = out_paddr_q;
  assign resp_fault  = out_fault_q;
  assign resp_region = out_region_q;
  assign fault_cnt   = fault_cnt_q;

endmodule
